// File: rtl/cart_upload_pkg.sv
// Shared types and constants for the cartridge upload reader.
// CRC export is enabled with CART_UPLOAD_CRC_EN.
package cart_upload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_LAT   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [7:0]  PAD_BYTE  = 8'hFF;
    localparam logic [16:0] SENT_MAX  = 17'h1FFFF;

    // Full 25-bit compare so anything at or above 2^17 is out of range.
    function automatic logic in_rom(
        input logic [24:0] addr,
        input logic [16:0] size
    );
        return addr < {8'd0, size};
    endfunction

endpackage

// File: rtl/crc16_byte.sv
// Combinational CRC-16/CCITT step over one byte, MSB first.
// Used by cart_upload only when CART_UPLOAD_CRC_EN is defined.
module crc16_byte
    import cart_upload_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    always_comb begin
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else       c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/cart_upload.sv
// HPS ioctl upload reader for the cartridge ROM RAM (port B).
// Define CART_UPLOAD_CRC_EN to add the crc output and its CRC-16 logic.
module cart_upload
    import cart_upload_pkg::*;
#(
    parameter int AW      = 15,
    parameter int MEM_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    input  logic [16:0]   rom_size,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_q,
    output logic [16:0]   bytes_sent,
`ifdef CART_UPLOAD_CRC_EN
    output logic [15:0]   crc,
`endif
    output logic          done
);

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [1:0]    lat_cnt;
    logic [1:0]    lat_dec;
    logic          upload_q;
    logic          done_seen;
    logic          rise;
    logic          req;
    logic          hit;
    logic          lat_end;
    logic          enter_resp;
    logic [16:0]   sent_nx;

    assign rise       = ioctl_upload & ~upload_q;
    assign req        = (state == ST_IDLE) & ioctl_rd & ioctl_upload;
    assign hit        = in_rom(ioctl_addr, rom_size);
    assign lat_dec    = lat_cnt - 2'd1;
    assign lat_end    = (state == ST_LAT) && (lat_dec == 2'd0);
    assign enter_resp = ioctl_upload & ((req & ~hit) | lat_end);
    assign sent_nx    = (bytes_sent == SENT_MAX) ? bytes_sent
                                                 : bytes_sent + 17'd1;

    assign ioctl_wait = ioctl_rd | (state == ST_ISSUE) | (state == ST_LAT);
    assign mem_rd     = (state == ST_ISSUE);
    assign mem_addr   = (state == ST_ISSUE) ? addr_q : '0;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            lat_cnt   <= '0;
            ioctl_din <= 8'h00;
        end else if (state != ST_IDLE && !ioctl_upload) begin
            // Host dropped the session mid-transfer.
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q <= ioctl_addr[AW-1:0];
                        if (hit) begin
                            state <= ST_ISSUE;
                        end else begin
                            state     <= ST_RESP;
                            ioctl_din <= PAD_BYTE;
                        end
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= ST_LAT;
                end
                ST_LAT: begin
                    lat_cnt <= lat_dec;
                    if (lat_dec == 2'd0) begin
                        ioctl_din <= mem_q;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Count is bumped on entry to RESP so it is visible alongside the data.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            upload_q   <= 1'b0;
            bytes_sent <= '0;
            done       <= 1'b0;
            done_seen  <= 1'b0;
        end else begin
            upload_q <= ioctl_upload;
            done     <= 1'b0;
            if (rise) begin
                bytes_sent <= '0;
                done_seen  <= 1'b0;
            end else if (enter_resp) begin
                bytes_sent <= sent_nx;
                if (sent_nx == rom_size && !done_seen) begin
                    done      <= 1'b1;
                    done_seen <= 1'b1;
                end
            end
        end
    end

`ifdef CART_UPLOAD_CRC_EN
    logic        rng_q;
    logic [15:0] crc_nx;

    crc16_byte u_crc (
        .crc_in  (crc),
        .data    (ioctl_din),
        .crc_out (crc_nx)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            crc   <= CRC_INIT;
            rng_q <= 1'b0;
        end else begin
            if (req) rng_q <= hit;
            if (rise) begin
                crc <= CRC_INIT;
            end else if (state == ST_RESP && ioctl_upload && rng_q) begin
                crc <= crc_nx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cart_upload.sv
// Directed bench for cart_upload: MEM_LAT=1 and MEM_LAT=3 instances
// share stimulus, each with its own pipelined RAM model.
module tb_cart_upload;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [16:0] rom_size;

    logic [7:0]  d1_din, d3_din;
    logic        d1_wait, d3_wait;
    logic [14:0] d1_maddr, d3_maddr;
    logic        d1_mrd, d3_mrd;
    logic [7:0]  d1_q, d3_q;
    logic [16:0] d1_sent, d3_sent;
    logic        d1_done, d3_done;
`ifdef CART_UPLOAD_CRC_EN
    logic [15:0] d1_crc, d3_crc;
`endif

    logic [7:0] mem [0:32767];
    logic [7:0] p3 [0:2];

    int n_chk  = 0;
    int n_fail = 0;
    int dcnt1  = 0;
    int dcnt3  = 0;

    always #5 clk_sys = ~clk_sys;

    cart_upload #(.AW(15), .MEM_LAT(1)) dut1 (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (d1_din),
        .ioctl_wait   (d1_wait),
        .rom_size     (rom_size),
        .mem_addr     (d1_maddr),
        .mem_rd       (d1_mrd),
        .mem_q        (d1_q),
        .bytes_sent   (d1_sent),
`ifdef CART_UPLOAD_CRC_EN
        .crc          (d1_crc),
`endif
        .done         (d1_done)
    );

    cart_upload #(.AW(15), .MEM_LAT(3)) dut3 (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (d3_din),
        .ioctl_wait   (d3_wait),
        .rom_size     (rom_size),
        .mem_addr     (d3_maddr),
        .mem_rd       (d3_mrd),
        .mem_q        (d3_q),
        .bytes_sent   (d3_sent),
`ifdef CART_UPLOAD_CRC_EN
        .crc          (d3_crc),
`endif
        .done         (d3_done)
    );

    always @(posedge clk_sys) d1_q <= mem[d1_maddr];

    always @(posedge clk_sys) begin
        p3[0] <= mem[d3_maddr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d3_q = p3[2];

    always @(posedge clk_sys) begin
        if (d1_done) dcnt1 <= dcnt1 + 1;
        if (d3_done) dcnt3 <= dcnt3 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic new_session();
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        tick();
    endtask

    // In-range read: dut1 responds at N+3, dut3 at N+5.
    task automatic rd_in(input logic [24:0] a, input logic [7:0] exp,
                         input logic [16:0] sent, input logic dn);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        #1;
        chk("wait_req", d1_wait, 1);
        tick();
        ioctl_rd = 1'b0;
        tick();
        tick();
        #1;
        chk("d1_din", d1_din, exp);
        chk("d1_wait_lo", d1_wait, 0);
        chk("d1_sent", d1_sent, sent);
        chk("d1_done", d1_done, dn);
        tick();
        tick();
        #1;
        chk("d3_din", d3_din, exp);
        chk("d3_sent", d3_sent, sent);
        chk("d3_done", d3_done, dn);
        tick();
    endtask

    initial begin
        int d1b, d3b;
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        mem[15'h123] = 8'h5A;
        mem[15'h010] = 8'hC3;

        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        rom_size     = '0;
        #2;
        chk("rst_din", d1_din, 8'h00);
        chk("rst_wait", d1_wait, 0);
        chk("rst_maddr", d1_maddr, 0);
        chk("rst_mrd", d1_mrd, 0);
        chk("rst_sent", d1_sent, 0);
        chk("rst_done", d1_done, 0);
`ifdef CART_UPLOAD_CRC_EN
        chk("rst_crc", d1_crc, 16'hFFFF);
`endif
        ioctl_rd = 1'b1;
        #1;
        chk("rst_wait_follows_rd", d1_wait, 1);
        ioctl_rd = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        tick();

        // In-range read with cycle-level wait checks.
        rom_size   = 17'd4096;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h123;
        #1;
        chk("t1_wait_n", d1_wait, 1);
        tick();
        ioctl_rd = 1'b0;
        #1;
        chk("t1_wait_n1", d1_wait, 1);
        chk("t1_mrd", d1_mrd, 1);
        chk("t1_maddr", d1_maddr, 15'h123);
        tick();
        #1;
        chk("t1_wait_n2", d1_wait, 1);
        chk("t1_mrd_n2", d1_mrd, 0);
        tick();
        #1;
        chk("t1_wait_n3", d1_wait, 0);
        chk("t1_din", d1_din, 8'h5A);
        chk("t1_sent", d1_sent, 1);
        tick();
        tick();
        #1;
        chk("t1_d3_din", d3_din, 8'h5A);
        chk("t1_d3_sent", d3_sent, 1);
        tick();

        // Out-of-range read.
        rom_size   = 17'd2048;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h800;
        #1;
        chk("t2_mrd_n", d1_mrd, 0);
        tick();
        ioctl_rd = 1'b0;
        #1;
        chk("t2_din", d1_din, 8'hFF);
        chk("t2_wait", d1_wait, 0);
        chk("t2_mrd", d1_mrd, 0);
        chk("t2_sent", d1_sent, 2);
        chk("t2_d3_din", d3_din, 8'hFF);
        tick();

        // Address above 2^17 with a maximal rom_size is still out of range.
        rom_size   = 17'h1FFFF;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h20000;
        tick();
        ioctl_rd = 1'b0;
        #1;
        chk("t2b_din", d1_din, 8'hFF);
        chk("t2b_mrd", d1_mrd, 0);
        tick();

        // Request while busy is ignored.
        rom_size   = 17'd2048;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h123;
        tick();
        ioctl_addr = 25'h900;
        #1;
        chk("t3_wait_busy", d1_wait, 1);
        tick();
        ioctl_rd = 1'b0;
        tick();
        #1;
        chk("t3_din", d1_din, 8'h5A);
        chk("t3_sent", d1_sent, 4);
        tick();
        tick();
        #1;
        chk("t3_d3_din", d3_din, 8'h5A);
        tick();

        // Full session of four bytes plus one pad read.
        new_session();
        #1;
        chk("t4_clr_sent", d1_sent, 0);
        chk("t4_clr_sent3", d3_sent, 0);
        rom_size = 17'd4;
        d1b = dcnt1;
        d3b = dcnt3;
        for (int i = 0; i < 4; i++)
            rd_in(25'(i), 8'h31 + 8'(i), 17'(i + 1), i == 3);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd4;
        tick();
        ioctl_rd = 1'b0;
        #1;
        chk("t4_pad", d1_din, 8'hFF);
        chk("t4_pad_done", d1_done, 0);
        chk("t4_pad_sent", d1_sent, 5);
        tick();
        tick();
        chk("t4_done_once1", dcnt1 - d1b, 1);
        chk("t4_done_once3", dcnt3 - d3b, 1);

        // Empty ROM: pad byte, no done.
        new_session();
        rom_size   = 17'd0;
        d1b        = dcnt1;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd0;
        tick();
        ioctl_rd = 1'b0;
        #1;
        chk("t5_empty_din", d1_din, 8'hFF);
        tick();
        tick();
        chk("t5_no_done", dcnt1 - d1b, 0);

`ifdef CART_UPLOAD_CRC_EN
        new_session();
        chk("t6_crc_clr", d1_crc, 16'hFFFF);
        rom_size = 17'd9;
        for (int i = 0; i < 9; i++)
            rd_in(25'(i), 8'h31 + 8'(i), 17'(i + 1), i == 8);
        chk("t6_crc1", d1_crc, 16'h29B1);
        chk("t6_crc3", d3_crc, 16'h29B1);
`endif

        // Abort during LAT on the MEM_LAT=3 instance.
        new_session();
        rom_size = 17'd4096;
        rd_in(25'h123, 8'h5A, 17'd1, 1'b0);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h010;
        tick();
        ioctl_rd = 1'b0;
        tick();
        ioctl_upload = 1'b0;
        #1;
        chk("t7_wait_lat", d3_wait, 1);
        tick();
        #1;
        chk("t7_wait_abort", d3_wait, 0);
        chk("t7_sent3", d3_sent, 1);
        chk("t7_sent1", d1_sent, 1);
        tick();
        tick();
        #1;
        chk("t7_wait_after", d3_wait, 0);
        chk("t7_din_kept", d3_din, 8'h5A);

        // Reset asserted during LAT.
        new_session();
        rom_size   = 17'd4096;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h123;
        tick();
        ioctl_rd = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("t8_wait", d3_wait, 0);
        chk("t8_din", d3_din, 8'h00);
        chk("t8_mrd", d3_mrd, 0);
        chk("t8_maddr", d3_maddr, 0);
        chk("t8_sent", d3_sent, 0);
        chk("t8_done", d3_done, 0);
`ifdef CART_UPLOAD_CRC_EN
        chk("t8_crc", d3_crc, 16'hFFFF);
`endif
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("t8_idle_wait", d3_wait, 0);
        chk("t8_idle_din", d3_din, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
